// File: rtl/seven_seg_scan_ctrl.sv
//==============================================================================
// Module      : seven_seg_scan_ctrl
// Description : Time-multiplexed scan controller for common-cathode 7-segment
//               digits with frame-atomic display update, blanking gap and
//               optional leading-zero suppression.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module seven_seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic                    lzs_en,
    output logic [3:0]              dec_value,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic                    load_ack,
    output logic                    frame_start
);

    localparam int c_cnt_max = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int c_cnt_w   = (c_cnt_max > 1) ? $clog2(c_cnt_max) : 1;
    localparam int c_idx_w   = $clog2(NUM_DIGITS);

    localparam logic [c_cnt_w-1:0] c_blank_last = c_cnt_w'(BLANK_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_show_last  = c_cnt_w'(REFRESH_DIV - 1);
    localparam logic [c_idx_w-1:0] c_idx_last   = c_idx_w'(NUM_DIGITS - 1);

    localparam logic [0:0] c_st_blank = 1'b0;
    localparam logic [0:0] c_st_show  = 1'b1;

    localparam logic [3:0] c_blank_val = 4'hF;

    logic [0:0]              r_state;
    logic [c_cnt_w-1:0]      r_cnt;
    logic [c_idx_w-1:0]      r_idx;
    logic [4*NUM_DIGITS-1:0] r_disp;
    logic [4*NUM_DIGITS-1:0] r_shadow;
    logic                    r_pending;
    logic [3:0]              r_dec_value;
    logic [NUM_DIGITS-1:0]   r_digit_en;
    logic                    r_load_ack;
    logic                    r_frame_start;

    logic [0:0]              w_state_nxt;
    logic [c_cnt_w-1:0]      w_cnt_nxt;
    logic [c_idx_w-1:0]      w_idx_nxt;
    logic                    w_wrap;
    logic [3:0]              w_cur_digit;
    logic                    w_upper_zero;
    logic                    w_suppress;
    logic [3:0]              w_dec_nxt;
    logic [NUM_DIGITS-1:0]   w_en_nxt;

    // Phase sequencing: BLANK -> SHOW -> BLANK (next digit)
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_idx_nxt   = r_idx;
        w_wrap      = 1'b0;
        if (r_state == c_st_blank) begin
            if (r_cnt == c_blank_last) begin
                w_state_nxt = c_st_show;
                w_cnt_nxt   = '0;
            end
        end else begin
            if (r_cnt == c_show_last) begin
                w_state_nxt = c_st_blank;
                w_cnt_nxt   = '0;
                if (r_idx == c_idx_last) begin
                    w_idx_nxt = '0;
                    w_wrap    = 1'b1;
                end else begin
                    w_idx_nxt = r_idx + 1'b1;
                end
            end
        end
    end

    // Outputs are computed from the next state so they line up with it once registered
    always_comb begin
        w_cur_digit  = 4'h0;
        w_upper_zero = 1'b1;
        w_en_nxt     = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (k == int'(w_idx_nxt)) begin
                w_cur_digit = r_disp[4*k +: 4];
                w_en_nxt[k] = 1'b1;
            end
            if ((k >= int'(w_idx_nxt)) && (r_disp[4*k +: 4] != 4'h0)) begin
                w_upper_zero = 1'b0;
            end
        end
        w_suppress = lzs_en && (w_idx_nxt != '0) && w_upper_zero;
        w_dec_nxt  = w_cur_digit;
        if ((w_state_nxt == c_st_blank) || w_suppress) begin
            w_en_nxt  = '0;
            w_dec_nxt = c_blank_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_st_blank;
            r_cnt         <= '0;
            r_idx         <= '0;
            r_disp        <= '0;
            r_shadow      <= '0;
            r_pending     <= 1'b0;
            r_dec_value   <= c_blank_val;
            r_digit_en    <= '0;
            r_load_ack    <= 1'b0;
            r_frame_start <= 1'b1;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_idx         <= w_idx_nxt;
            r_dec_value   <= w_dec_nxt;
            r_digit_en    <= w_en_nxt;
            r_frame_start <= w_wrap;
            r_load_ack    <= w_wrap && r_pending;
            if (w_wrap && r_pending) begin
                r_disp    <= r_shadow;
                r_pending <= 1'b0;
            end
            // A load coinciding with a commit lands in the shadow and stays pending
            if (load) begin
                r_shadow  <= value_in;
                r_pending <= 1'b1;
            end
        end
    end

    assign dec_value   = r_dec_value;
    assign digit_en    = r_digit_en;
    assign load_ack    = r_load_ack;
    assign frame_start = r_frame_start;

endmodule

`default_nettype wire

// File: tb/tb_seven_seg_scan_ctrl.sv
//==============================================================================
// Module      : tb_seven_seg_scan_ctrl
// Description : Directed self-checking bench for seven_seg_scan_ctrl
//               (4 digits, 4 lit cycles, 2 blank cycles: slot 6, frame 24).
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_seven_seg_scan_ctrl;

    logic        clk;
    logic        rst;
    logic        load;
    logic [15:0] value_in;
    logic        lzs_en;
    logic [3:0]  dec_value;
    logic [3:0]  digit_en;
    logic        load_ack;
    logic        frame_start;

    int cyc;
    int n_assert;
    int n_fail;

    seven_seg_scan_ctrl #(
        .NUM_DIGITS   (4),
        .REFRESH_DIV  (4),
        .BLANK_CYCLES (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .value_in    (value_in),
        .lzs_en      (lzs_en),
        .dec_value   (dec_value),
        .digit_en    (digit_en),
        .load_ack    (load_ack),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    // Expected display for the current cycle given the word being shown
    task automatic expect_cycle(input logic [15:0] word, input logic lzs, input logic ack);
        int pos;
        int d;
        logic [3:0] e_en;
        logic [3:0] e_val;
        pos = cyc % 24;
        d   = pos / 6;
        if ((pos % 6) < 2) begin
            e_en  = 4'b0000;
            e_val = 4'hF;
        end else if (lzs && (d != 0) && ((word >> (4*d)) == 16'h0)) begin
            e_en  = 4'b0000;
            e_val = 4'hF;
        end else begin
            e_en  = 4'(1 << d);
            e_val = word[4*d +: 4];
        end
        chk("digit_en", 16'(digit_en), 16'(e_en));
        chk("dec_value", 16'(dec_value), 16'(e_val));
        chk("frame_start", 16'(frame_start), 16'(pos == 0));
        chk("load_ack", 16'(load_ack), 16'((pos == 0) ? ack : 1'b0));
    endtask

    task automatic run_until_wrap(input logic [15:0] word, input logic lzs, input logic ack);
        do begin
            expect_cycle(word, lzs, ack);
            step();
        end while ((cyc % 24) != 0);
    endtask

    task automatic run_to(input int target, input logic [15:0] word, input logic lzs, input logic ack);
        while (cyc < target) begin
            expect_cycle(word, lzs, ack);
            step();
        end
    endtask

    task automatic load_step(input logic [15:0] val, input logic [15:0] word, input logic lzs,
                             input logic ack);
        value_in = val;
        load     = 1'b1;
        expect_cycle(word, lzs, ack);
        step();
        load     = 1'b0;
    endtask

    initial begin
        cyc      = 0;
        n_assert = 0;
        n_fail   = 0;
        rst      = 1'b1;
        load     = 1'b0;
        value_in = 16'h0000;
        lzs_en   = 1'b0;

        // Reset held for three cycles
        step();
        chk("rst_digit_en", 16'(digit_en), 16'h0);
        chk("rst_dec_value", 16'(dec_value), 16'hF);
        chk("rst_load_ack", 16'(load_ack), 16'h0);
        step();
        step();
        chk("rst_digit_en", 16'(digit_en), 16'h0);
        chk("rst_dec_value", 16'(dec_value), 16'hF);
        rst = 1'b0;
        cyc = 0;

        // First frame shows zeros, load 1234 at cycle 1, commit at cycle 24
        expect_cycle(16'h0000, 1'b0, 1'b0);
        step();
        load_step(16'h1234, 16'h0000, 1'b0, 1'b0);
        run_until_wrap(16'h0000, 1'b0, 1'b0);
        run_until_wrap(16'h1234, 1'b0, 1'b1);

        // Leading-zero suppression
        lzs_en = 1'b1;
        load_step(16'h0050, 16'h1234, 1'b1, 1'b0);
        run_until_wrap(16'h1234, 1'b1, 1'b0);
        run_until_wrap(16'h0050, 1'b1, 1'b1);
        load_step(16'h0000, 16'h0050, 1'b1, 1'b0);
        run_until_wrap(16'h0050, 1'b1, 1'b0);
        run_until_wrap(16'h0000, 1'b1, 1'b1);

        // Mid-frame loads: idx 2 then idx 3, last one wins
        lzs_en = 1'b0;
        run_to(158, 16'h0000, 1'b0, 1'b0);
        load_step(16'h1111, 16'h0000, 1'b0, 1'b0);
        run_to(164, 16'h0000, 1'b0, 1'b0);
        load_step(16'h2222, 16'h0000, 1'b0, 1'b0);
        run_until_wrap(16'h0000, 1'b0, 1'b0);
        run_until_wrap(16'h2222, 1'b0, 1'b1);

        // Load on the commit cycle of a pending word
        load_step(16'h1234, 16'h2222, 1'b0, 1'b0);
        run_to(215, 16'h2222, 1'b0, 1'b0);
        load_step(16'h9999, 16'h2222, 1'b0, 1'b0);
        run_until_wrap(16'h1234, 1'b0, 1'b1);
        run_until_wrap(16'h9999, 1'b0, 1'b1);
        run_until_wrap(16'h9999, 1'b0, 1'b0);

        // Reset during SHOW of digit 2 with a load pending
        load_step(16'h5678, 16'h9999, 1'b0, 1'b0);
        run_to(302, 16'h9999, 1'b0, 1'b0);
        expect_cycle(16'h9999, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        chk("midrst_digit_en", 16'(digit_en), 16'h0);
        chk("midrst_dec_value", 16'(dec_value), 16'hF);
        chk("midrst_frame_start", 16'(frame_start), 16'h1);
        chk("midrst_load_ack", 16'(load_ack), 16'h0);
        rst = 1'b0;
        cyc = 0;
        run_until_wrap(16'h0000, 1'b0, 1'b0);
        run_until_wrap(16'h0000, 1'b0, 1'b0);

        // Non-BCD digit passes through
        load_step(16'h00A0, 16'h0000, 1'b0, 1'b0);
        run_until_wrap(16'h0000, 1'b0, 1'b0);
        run_until_wrap(16'h00A0, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
